// File: rtl/spi_reg_pkg.sv
// Shared types and frame-layout constants for the SPI register bridge.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_WAIT,
    DATA,
    WR,
    DONE
  } state_e;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  // Field positions within the full 16-bit frame.
  localparam int unsigned RW_BIT  = 15;
  localparam int unsigned ADDR_HI = 11;
  localparam int unsigned ADDR_LO = 8;

  // The same fields as they sit in the RX shifter once only the command
  // byte has been shifted in.
  localparam int unsigned CMD_RW_POS  = RW_BIT  - (FRAME_BITS - CMD_BITS);
  localparam int unsigned CMD_ADDR_HI = ADDR_HI - (FRAME_BITS - CMD_BITS);
  localparam int unsigned CMD_ADDR_LO = ADDR_LO - (FRAME_BITS - CMD_BITS);

  // Bit-counter values seen on the last rise of the command and of the frame.
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus bundle between the SPI bridge (master) and the register file (slave).
interface spi_reg_bridge_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] address;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] read_data;

  modport master (
    output address,
    output write_en,
    output read_en,
    output data_in,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_en,
    input  read_en,
    input  data_in,
    output read_data
  );

endinterface

// File: rtl/spi_reg_bridge_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, plus a third flop for
// single-clk rise/fall pulses of the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchronizer chain.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history flops; all clear low so a pin held low
  // through reset does not produce a spurious edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning 16-bit frames into single-cycle register-bus
// reads and writes; read data is returned on miso in the same frame.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic clk,
  input  logic resetb,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  spi_reg_bridge_if.master bus
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_n_sync, cs_n_fall, cs_n_rise_unused;

  logic mosi_meta_q, mosi_meta_d;
  logic mosi_sync_q, mosi_sync_d;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   rx_shift;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic                    rw_q, rw_d;
  logic                    miso_q, miso_d;
  logic [ADDR_W-1:0]       address_q, address_d;
  logic [DATA_W-1:0]       data_in_q, data_in_d;

  sync_edge_det u_sclk_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (sclk),
    .dout   (sclk_lvl_unused),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  sync_edge_det u_cs_n_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (cs_n),
    .dout   (cs_n_sync),
    .rise   (cs_n_rise_unused),
    .fall   (cs_n_fall)
  );

  // Next-state, shifter and output-register logic for the frame FSM.
  always_comb begin
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    miso_d    = miso_q;
    address_d = address_q;
    data_in_d = data_in_q;

    rx_shift  = (rx_q << 1) | {{(FRAME_BITS-1){1'b0}}, mosi_sync_q};

    // Deselect aborts everything except the single-cycle write strobe.
    if (cs_n_sync && state_q != WR) begin
      state_d = IDLE;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
      rw_d    = 1'b0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d  = '0;
          rx_d   = '0;
          tx_d   = '0;
          rw_d   = 1'b0;
          miso_d = 1'b0;
          if (cs_n_fall) begin
            state_d = CMD;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            rx_d  = rx_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_CMD_LAST) begin
              address_d = ADDR_W'(rx_shift[CMD_ADDR_HI:CMD_ADDR_LO]);
              rw_d      = rx_shift[CMD_RW_POS];
              state_d   = rx_shift[CMD_RW_POS] ? RD_REQ : DATA;
            end
          end
        end

        RD_REQ: begin
          state_d = RD_WAIT;
        end

        RD_WAIT: begin
          tx_d    = bus.read_data;
          state_d = DATA;
        end

        DATA: begin
          if (sclk_rise) begin
            rx_d  = rx_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_FRAME_LAST) begin
              if (rw_q) begin
                state_d = DONE;
              end else begin
                data_in_d = rx_shift[DATA_W-1:0];
                state_d   = WR;
              end
            end
          end else if (sclk_fall && rw_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end

        WR: begin
          state_d = DONE;
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, shifters, mosi synchronizer and registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      address_q   <= '0;
      data_in_q   <= '0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      miso_q      <= miso_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
    end
  end

  assign miso         = miso_q;
  assign bus.address  = address_q;
  assign bus.write_en = (state_q == WR);
  assign bus.read_en  = (state_q == RD_REQ);
  assign bus.data_in  = data_in_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: drives SPI frames, models the
// downstream register file, and checks strobes and miso against an
// array-based reference of the register contents.
module tb_spi_reg_bridge;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  spi_reg_bridge_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  spi_reg_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .resetb (resetb),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Downstream register file and the bench's expected contents.
  logic [7:0] mem     [16];
  logic [7:0] ref_mem [16];

  always @(posedge clk) begin
    if (bus.read_en)  bus.read_data <= mem[bus.address];
    if (bus.write_en) mem[bus.address] = bus.data_in;
  end

  // Strobe monitor, sampled mid-cycle.
  int         wr_cnt, rd_cnt, both_cnt;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  always @(negedge clk) begin
    if (bus.write_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.address;
      wr_data = bus.data_in;
    end
    if (bus.read_en) begin
      rd_cnt  = rd_cnt + 1;
      rd_addr = bus.address;
    end
    if (bus.write_en && bus.read_en) both_cnt = both_cnt + 1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rx_byte;
  logic       obs_miso, obs_we, obs_re;
  logic [3:0] obs_addr;
  logic [7:0] obs_din;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends nbits sclk pulses (bits past 16 are random), then deselects.
  // miso is sampled just before rises 9..16. rst_at >= 0 pulses resetb
  // low during that bit and clears the strobe counters afterwards.
  task automatic run_frame(input logic [15:0] f, input int nbits, input int rst_at);
    rx_byte = '0;
    wr_cnt  = 0;
    rd_cnt  = 0;
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? f[15-i] : 1'($urandom);
      tick(4);
      if (i >= 8 && i < 16) rx_byte[15-i] = miso;
      if (i == rst_at) begin
        resetb = 1'b0;
        #1;
        obs_miso = miso;
        obs_we   = bus.write_en;
        obs_re   = bus.read_en;
        obs_addr = bus.address;
        obs_din  = bus.data_in;
        tick(2);
        resetb = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
      end
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b expected 0", miso); end
    tests_run++; if (bus.write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_write_en: got %b expected 0", bus.write_en); end
    tests_run++; if (bus.read_en !== 1'b0) begin tests_failed++; $display("FAIL reset_read_en: got %b expected 0", bus.read_en); end
    tests_run++; if (bus.address !== 4'h0) begin tests_failed++; $display("FAIL reset_address: got %h expected 0", bus.address); end
    tests_run++; if (bus.data_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data_in: got %h expected 00", bus.data_in); end
    resetb = 1'b1;
    tick(4);
  endtask

  task automatic test_write();
    run_frame(16'h02A5, 16, -1);
    ref_mem[2] = 8'hA5;
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL write_count: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_addr !== 4'h2) begin tests_failed++; $display("FAIL write_addr: got %h expected 2", wr_addr); end
    tests_run++; if (wr_data !== 8'hA5) begin tests_failed++; $display("FAIL write_data: got %h expected a5", wr_data); end
    tests_run++; if (rd_cnt !== 0) begin tests_failed++; $display("FAIL write_no_read: got %0d expected 0", rd_cnt); end
  endtask

  task automatic test_read();
    mem[1] = 8'h3C;
    ref_mem[1] = 8'h3C;
    run_frame(16'h8100, 16, -1);
    tests_run++; if (rd_cnt !== 1) begin tests_failed++; $display("FAIL read_count: got %0d expected 1", rd_cnt); end
    tests_run++; if (rd_addr !== 4'h1) begin tests_failed++; $display("FAIL read_addr: got %h expected 1", rd_addr); end
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL read_no_write: got %0d expected 0", wr_cnt); end
    tests_run++; if (rx_byte !== ref_mem[1]) begin tests_failed++; $display("FAIL read_miso: got %h expected %h", rx_byte, ref_mem[1]); end
    tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL read_miso_idle: got %b expected 0", miso); end
  endtask

  task automatic test_abort();
    run_frame(16'h0377, 12, -1);
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL abort_no_write: got %0d expected 0", wr_cnt); end
    tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL abort_miso: got %b expected 0", miso); end
    tests_run++; if (bus.address !== 4'h3) begin tests_failed++; $display("FAIL abort_addr_held: got %h expected 3", bus.address); end
    run_frame(16'h0311, 16, -1);
    ref_mem[3] = 8'h11;
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL abort_next_count: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_addr !== 4'h3 || wr_data !== 8'h11) begin tests_failed++; $display("FAIL abort_next_write: got %h/%h expected 3/11", wr_addr, wr_data); end
  endtask

  task automatic test_reserved_and_long();
    run_frame(16'h7F5A, 16, -1);
    ref_mem[15] = 8'h5A;
    tests_run++; if (wr_cnt !== 1 || wr_addr !== 4'hF || wr_data !== 8'h5A) begin tests_failed++; $display("FAIL reserved_write: got %0d %h/%h expected 1 f/5a", wr_cnt, wr_addr, wr_data); end
    run_frame(16'h0C96, 20, -1);
    ref_mem[12] = 8'h96;
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL long_frame_count: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_addr !== 4'hC || wr_data !== 8'h96) begin tests_failed++; $display("FAIL long_frame_write: got %h/%h expected c/96", wr_addr, wr_data); end
    tests_run++; if (rd_cnt !== 0) begin tests_failed++; $display("FAIL long_frame_no_read: got %0d expected 0", rd_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    mem[5] = 8'hFF;
    ref_mem[5] = 8'hFF;
    run_frame(16'h8500, 16, 10);
    tests_run++; if (rx_byte[7:5] !== 3'b111) begin tests_failed++; $display("FAIL rst_pre_bits: got %b expected 111", rx_byte[7:5]); end
    tests_run++; if (obs_miso !== 1'b0) begin tests_failed++; $display("FAIL rst_miso: got %b expected 0", obs_miso); end
    tests_run++; if (obs_addr !== 4'h0 || obs_din !== 8'h00) begin tests_failed++; $display("FAIL rst_bus: got %h/%h expected 0/00", obs_addr, obs_din); end
    tests_run++; if (obs_we !== 1'b0 || obs_re !== 1'b0) begin tests_failed++; $display("FAIL rst_strobes: got %b%b expected 00", obs_we, obs_re); end
    tests_run++; if (rx_byte[4:0] !== 5'b0) begin tests_failed++; $display("FAIL rst_post_bits: got %b expected 00000", rx_byte[4:0]); end
    tests_run++; if (rd_cnt !== 0 || wr_cnt !== 0) begin tests_failed++; $display("FAIL rst_no_strobe: got %0d/%0d expected 0/0", rd_cnt, wr_cnt); end
    tests_run++; if (bus.address !== 4'h0) begin tests_failed++; $display("FAIL rst_no_resync: got %h expected 0", bus.address); end
    run_frame(16'h0A3C, 16, -1);
    ref_mem[10] = 8'h3C;
    tests_run++; if (wr_cnt !== 1 || wr_addr !== 4'hA || wr_data !== 8'h3C) begin tests_failed++; $display("FAIL rst_next_frame: got %0d %h/%h expected 1 a/3c", wr_cnt, wr_addr, wr_data); end
  endtask

  task automatic test_back_to_back();
    run_frame(16'h00FF, 16, -1);
    ref_mem[0] = 8'hFF;
    tests_run++; if (wr_cnt !== 1 || wr_addr !== 4'h0 || wr_data !== 8'hFF) begin tests_failed++; $display("FAIL b2b_write: got %0d %h/%h expected 1 0/ff", wr_cnt, wr_addr, wr_data); end
    run_frame(16'h8000, 16, -1);
    tests_run++; if (rd_cnt !== 1 || rd_addr !== 4'h0 || wr_cnt !== 0) begin tests_failed++; $display("FAIL b2b_read: got %0d %h wr %0d expected 1 0 wr 0", rd_cnt, rd_addr, wr_cnt); end
    tests_run++; if (rx_byte !== ref_mem[0]) begin tests_failed++; $display("FAIL b2b_miso: got %h expected %h", rx_byte, ref_mem[0]); end
  endtask

  task automatic test_random();
    logic       rw;
    logic [3:0] a;
    logic [7:0] d;
    for (int n = 0; n < 16; n++) begin
      rw = 1'($urandom);
      a  = 4'($urandom);
      d  = 8'($urandom);
      run_frame({rw, 3'($urandom), a, d}, 16, -1);
      if (rw) begin
        tests_run++; if (rd_cnt !== 1 || rd_addr !== a || wr_cnt !== 0) begin tests_failed++; $display("FAIL rand_read_%0d: got %0d %h wr %0d expected 1 %h wr 0", n, rd_cnt, rd_addr, wr_cnt, a); end
        tests_run++; if (rx_byte !== ref_mem[a]) begin tests_failed++; $display("FAIL rand_miso_%0d: got %h expected %h", n, rx_byte, ref_mem[a]); end
      end else begin
        ref_mem[a] = d;
        tests_run++; if (wr_cnt !== 1 || wr_addr !== a || wr_data !== d || rd_cnt !== 0) begin tests_failed++; $display("FAIL rand_write_%0d: got %0d %h/%h rd %0d expected 1 %h/%h rd 0", n, wr_cnt, wr_addr, wr_data, rd_cnt, a, d); end
        tests_run++; if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL rand_write_miso_%0d: got %h expected 00", n, rx_byte); end
      end
    end
    tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL strobes_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    wr_cnt = 0;
    rd_cnt = 0;
    both_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    tick(3);
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reserved_and_long();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

SPI slave (mode 0) that turns 16-bit serial frames into single-cycle transactions on the device register bus. It drives `address`/`write_en`/`read_en`/`data_in` into the register-file block directly downstream and returns that block's `read_data` on `miso`. All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `ADDR_W`, 4: register address width.
- `DATA_W`, 8: register data width.

Ports:
- `clk`  in  1  system clock
- `resetb`  in  1  reset, asynchronous, active-low
- `sclk`  in  1  SPI clock, async, idle low
- `cs_n`  in  1  SPI chip select, async, active-low
- `mosi`  in  1  SPI data in, async
- `miso`  out  1  SPI data out; 0 when deselected
- `address`  out  ADDR_W  register address, held from capture until next frame's capture
- `write_en`  out  1  one-`clk` write strobe
- `read_en`  out  1  one-`clk` read strobe
- `data_in`  out  DATA_W  write data, valid with `write_en`
- `read_data`  in  DATA_W  registered read return, valid 1 `clk` after `read_en`

## Operation
- Frame, MSB first: bit15 = R/W (1 = read); bits 14:12 reserved, ignored; bits 11:8 = address; bits 7:0 = write data (write) or don't-care (read).
- MOSI is sampled on `sclk` rising edges. MISO changes on `sclk` falling edges.
- FSM states and transitions:
  - IDLE: waits for `cs_n` low, then CMD. Bit counter is cleared.
  - CMD: shifts 8 bits. After the 8th rise, `address` is latched. Read goes to RD_REQ; write goes to DATA.
  - RD_REQ: `read_en`=1 for one `clk`, then RD_WAIT.
  - RD_WAIT: one `clk`. `read_data` is loaded into the TX shifter, then DATA.
  - DATA: shifts 8 bits. On a read, each falling edge drives the next TX bit MSB first; bit 7 is driven on the falling edge after the 8th rise. After the 16th rise: write goes to WR; read goes to DONE.
  - WR: `write_en`=1 and `data_in` = RX byte for one `clk`, then DONE.
  - DONE: ignores further `sclk` edges until `cs_n` goes high, then IDLE.
- `cs_n` high in any state other than WR returns the FSM to IDLE next `clk`. No strobe is issued, the counter is cleared and `miso`=0. WR always completes, being a single cycle.
- The bridge does not decode addresses. All 16 addresses are forwarded.
- Reset values: `miso`=0, `write_en`=0, `read_en`=0, `address`=0, `data_in`=0, state IDLE, shifters and counter 0. Reset mid-frame aborts the frame. The bridge resyncs only at the next `cs_n` falling edge.

## Timing
- `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchronizer. Edge detection uses a third flop, so latency from pin edge to internal event is 3 `clk`.
- Required SPI rates: `sclk` high ≥4 `clk` and low ≥4 `clk`. `cs_n` setup to the first rise ≥4 `clk`. `cs_n` high between frames ≥4 `clk`.
- Read path, counted from the 8th rise detection (T):
  - T+1: `read_en`.
  - T+2: `read_data` valid.
  - T+3: loaded into TX shifter.
  - The earliest falling-edge detection is T+4, so this meets the constraint above.
- `write_en` asserts 1 `clk` after the 16th rise detection.
- At most one strobe per frame. `read_en` and `write_en` are never high together.

## Structure
- Package `spi_reg_pkg` holds:
  - state enum (IDLE, CMD, RD_REQ, RD_WAIT, DATA, WR, DONE);
  - `FRAME_BITS`=16 and `CMD_BITS`=8;
  - R/W bit index 15;
  - address field position 11:8.
- Sub-module `sync_edge_det` is a 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated for `sclk` and `cs_n`. `mosi` uses the synchronizer only.
- The top level holds the FSM, 4-bit bit counter, RX shift register (16 bits) and TX shift register (8 bits).

## Test plan
- Write frame 0x02A5 at `sclk` = `clk`/8 -> exactly one `write_en` with `address`=2, `data_in`=0xA5. `read_en` never asserts.
- Read frame 0x8100, downstream model returns 0x3C one cycle after `read_en` -> one `read_en` with `address`=1; `miso` bits over falling edges 8–15 = 0,0,1,1,1,1,0,0.
- Write frame to 0x3 with `cs_n` raised after 12 bits -> no `write_en`, FSM in IDLE within 4 `clk`, `miso`=0. The next full write frame to 0x3 with 0x11 succeeds.
- Reserved bits set (frame 0x7F5A) -> write to `address`=0xF, `data_in`=0x5A. 20 `sclk` pulses in one frame -> still exactly one `write_en`.
- `resetb` pulsed low during bit 10 of a read -> all outputs 0 immediately, no strobe. A frame that starts after a fresh `cs_n` fall completes normally.
- Back-to-back frames (write 0x0 with 0xFF, then read 0x0) with minimum 4-`clk` `cs_n` gap -> write strobe, then read strobe, and `miso` returns 0xFF.
